srs_ifft_rd: RTL and testbench

- Reader at the far end of the per-antenna IFFT RAMs that the SRS sequence generators write.
- After SRS generation completes, reads one OFDM symbol of frequency-domain samples per active antenna, addresses 0..N-1.
- Streams the samples to the IFFT core over a valid/ready interface, antenna 0 first, then antenna 1.
- Sits between the SRS top level and the IFFT; owns the RAM read ports.

---
 rtl/srs_pkg.sv | 46 ++++
 rtl/srs_skid_fifo.sv | 61 ++++++
 rtl/srs_ifft_rd.sv | 180 ++++++++++++++++++
 tb/tb_srs_ifft_rd.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/srs_pkg.sv
// Shared types and decode helpers for the SRS IFFT RAM reader.
// Pure declarations: no latency, no flow control.
// Sample entries carry antenna and symbol-boundary tags alongside the IQ word.
package srs_pkg;

    localparam int SAMP_W = 24;
    localparam int ADDR_W = 12;

    localparam logic [1:0] AP_ANT0  = 2'b00;
    localparam logic [1:0] AP_ANT01 = 2'b01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ANT0 = 2'd1,
        RD_ANT1 = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // Read-side tag that travels alongside a RAM access until its rdata lands.
    typedef struct packed {
        logic vld;
        logic ant;
        logic sop;
        logic eop;
    } tag_t;

    typedef struct packed {
        logic              ant;
        logic              sop;
        logic              eop;
        logic [SAMP_W-1:0] data;
    } samp_t;

    // Symbol length minus one, so the address counter compares without an adder.
    function automatic logic [ADDR_W-1:0] ifft_nm1(input logic [1:0] sel);
        logic [ADDR_W-1:0] n_m1;
        case (sel)
            2'b00:   n_m1 = 12'd4095;
            2'b01:   n_m1 = 12'd2047;
            2'b10:   n_m1 = 12'd1023;
            default: n_m1 = 12'd511;
        endcase
        return n_m1;
    endfunction

endpackage

// File: rtl/srs_skid_fifo.sv
// Generic synchronous FIFO with a combinational head and occupancy count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: the producer must respect count; a pop frees space for a same-cycle push.
module srs_skid_fifo #(
    parameter  int WIDTH = 27,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/srs_ifft_rd.sv
// Reads one OFDM symbol per active antenna from the IFFT RAMs and streams it to the IFFT.
// Latency: first dout_valid RAM_LAT+2 cycles after start; 1 sample/cycle with ready high.
// Backpressure: RAM reads issue only while FIFO occupancy plus reads in flight < FIFO_DEPTH.
module srs_ifft_rd
    import srs_pkg::*;
#(
    parameter int RAM_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [1:0]        ifft_size_sel,
    input  logic [1:0]        ap_num,
    output logic              ant0_ifft_ram_rd,
    output logic [ADDR_W-1:0] ant0_ifft_ram_raddr,
    input  logic [SAMP_W-1:0] ant0_ifft_ram_rdata,
    output logic              ant1_ifft_ram_rd,
    output logic [ADDR_W-1:0] ant1_ifft_ram_raddr,
    input  logic [SAMP_W-1:0] ant1_ifft_ram_rdata,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [SAMP_W-1:0] dout_data,
    output logic              dout_ant,
    output logic              dout_sop,
    output logic              dout_eop
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + RAM_LAT + 1);

    state_t            state;
    logic [ADDR_W-1:0] n_m1;
    logic [ADDR_W-1:0] addr_cnt;
    logic [1:0]        ap_q;

    tag_t              tag_pipe [RAM_LAT];
    tag_t              issue_tag;
    tag_t              ram_tag;
    logic [OCC_W-1:0]  inflight;
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    samp_t             push_ent;
    samp_t             head;
    logic              rd_en;
    logic              cur_ant;
    logic              wrap;
    logic              pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_LAT; i++) begin
            inflight = inflight + OCC_W'(tag_pipe[i].vld);
        end
    end

    // Every issued read reserves a FIFO slot up front, so the push side never sees a full FIFO.
    assign occ     = OCC_W'(fifo_count) + inflight;
    assign cur_ant = (state == RD_ANT1);
    assign rd_en   = ((state == RD_ANT0) || (state == RD_ANT1)) && (occ < OCC_W'(FIFO_DEPTH));
    assign wrap    = (addr_cnt == n_m1);

    assign ant0_ifft_ram_rd    = rd_en && !cur_ant;
    assign ant1_ifft_ram_rd    = rd_en && cur_ant;
    assign ant0_ifft_ram_raddr = addr_cnt;
    assign ant1_ifft_ram_raddr = addr_cnt;

    always_comb begin
        issue_tag     = '0;
        issue_tag.vld = rd_en;
        issue_tag.ant = cur_ant;
        issue_tag.sop = (addr_cnt == '0);
        issue_tag.eop = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= issue_tag;
            for (int i = 1; i < RAM_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign ram_tag = tag_pipe[RAM_LAT-1];

    always_comb begin
        push_ent      = '0;
        push_ent.ant  = ram_tag.ant;
        push_ent.sop  = ram_tag.sop;
        push_ent.eop  = ram_tag.eop;
        push_ent.data = ram_tag.ant ? ant1_ifft_ram_rdata : ant0_ifft_ram_rdata;
    end

    srs_skid_fifo #(
        .WIDTH ($bits(samp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (ram_tag.vld),
        .push_dat (push_ent),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    assign dout_valid = !fifo_empty;
    assign dout_data  = head.data;
    assign dout_ant   = head.ant;
    assign dout_sop   = head.sop && dout_valid;
    assign dout_eop   = head.eop && dout_valid;
    assign pop        = dout_valid && dout_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            n_m1     <= '0;
            ap_q     <= '0;
            addr_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_m1     <= ifft_nm1(ifft_size_sel);
                        ap_q     <= ap_num;
                        addr_cnt <= '0;
                        if ((ap_num == AP_ANT0) || (ap_num == AP_ANT01)) begin
                            state <= RD_ANT0;
                            busy  <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RD_ANT0: begin
                    if (rd_en) begin
                        if (wrap) begin
                            addr_cnt <= '0;
                            state    <= (ap_q == AP_ANT01) ? RD_ANT1 : DRAIN;
                        end else begin
                            addr_cnt <= addr_cnt + ADDR_W'(1);
                        end
                    end
                end
                RD_ANT1: begin
                    if (rd_en) begin
                        if (wrap) begin
                            addr_cnt <= '0;
                            state    <= DRAIN;
                        end else begin
                            addr_cnt <= addr_cnt + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    // Retire in the same edge that pops the final sample, so done trails it by one cycle.
                    if ((inflight == '0) &&
                        (fifo_empty || ((fifo_count == CNT_W'(1)) && pop))) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srs_ifft_rd.sv
// Directed bench for srs_ifft_rd: per-pass expectations queued at start, checked by a negedge monitor.
module tb_srs_ifft_rd;

    localparam int RAM_LAT    = 1;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic        ant;
        logic        sop;
        logic        eop;
        logic [23:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [1:0]  ifft_size_sel = 2'b11;
    logic [1:0]  ap_num = 2'b00;
    logic        ant0_rd, ant1_rd;
    logic [11:0] ant0_raddr, ant1_raddr;
    logic [23:0] ant0_rdata = '0;
    logic [23:0] ant1_rdata = '0;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic [23:0] dout_data;
    logic        dout_ant, dout_sop, dout_eop;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sbq[$];
    int   issued = 0;
    int   xfer = 0;
    int   done_cnt = 0;
    bit   exp_done_q = 0;
    bit   nopass_exp = 0;
    bit   stall_q = 0;
    logic [23:0] stall_dat = '0;
    bit   rnd_mode = 0;

    srs_ifft_rd #(.RAM_LAT(RAM_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .busy                (busy),
        .done                (done),
        .ifft_size_sel       (ifft_size_sel),
        .ap_num              (ap_num),
        .ant0_ifft_ram_rd    (ant0_rd),
        .ant0_ifft_ram_raddr (ant0_raddr),
        .ant0_ifft_ram_rdata (ant0_rdata),
        .ant1_ifft_ram_rd    (ant1_rd),
        .ant1_ifft_ram_raddr (ant1_raddr),
        .ant1_ifft_ram_rdata (ant1_rdata),
        .dout_valid          (dout_valid),
        .dout_ready          (dout_ready),
        .dout_data           (dout_data),
        .dout_ant            (dout_ant),
        .dout_sop            (dout_sop),
        .dout_eop            (dout_eop)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [23:0] ram0(input int a);
        logic [11:0] hi, lo;
        hi = 12'(a);
        lo = 12'(a * 7 + 5);
        return {hi, lo};
    endfunction

    function automatic logic [23:0] ram1(input int a);
        logic [11:0] hi, lo;
        hi = 12'(a) ^ 12'hFFF;
        lo = 12'(a * 3 + 1);
        return {hi, lo};
    endfunction

    // Single-cycle-latency RAM models.
    always @(posedge clk) begin
        if (ant0_rd) ant0_rdata <= ram0(int'(ant0_raddr));
        if (ant1_rd) ant1_rdata <= ram1(int'(ant1_raddr));
    end

    initial forever begin
        @(posedge clk);
        #1;
        dout_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: done timing, stall stability, read credit, and scoreboard pops.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q    = 0;
            exp_done_q = 0;
            issued     = 0;
            xfer       = 0;
        end else begin
            if (done || exp_done_q || nopass_exp)
                chk("done_pulse", 32'(done), 32'(exp_done_q | nopass_exp));
            if (done) done_cnt++;
            exp_done_q = 0;
            if (stall_q)
                chk("stall_stable", {7'b0, dout_valid, dout_data}, {7'b0, 1'b1, stall_dat});
            if (ant0_rd || ant1_rd) begin
                chk("rd_credit", 32'((ant0_rd && ant1_rd) || (issued - xfer >= FIFO_DEPTH)), 32'd0);
                issued++;
            end
            if (dout_valid && dout_ready) begin
                chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("sample", {5'b0, dout_ant, dout_sop, dout_eop, dout_data}, {5'b0, e});
                    if (sbq.size() == 0) exp_done_q = 1;
                end
                xfer++;
            end
            stall_q   = dout_valid && !dout_ready;
            stall_dat = dout_data;
        end
    end

    task automatic push_pass(input logic [1:0] sel, input logic [1:0] ap);
        int n;
        int nant;
        n    = 4096 >> sel;
        nant = (ap == 2'b01) ? 2 : 1;
        for (int ant = 0; ant < nant; ant++) begin
            for (int a = 0; a < n; a++) begin
                exp_t e;
                e.ant  = 1'(ant);
                e.sop  = (a == 0);
                e.eop  = (a == n - 1);
                e.data = (ant == 0) ? ram0(a) : ram1(a);
                sbq.push_back(e);
            end
        end
    endtask

    task automatic do_start(input logic [1:0] sel, input logic [1:0] ap, input bit is_pass);
        @(posedge clk);
        #1;
        ifft_size_sel = sel;
        ap_num        = ap;
        start         = 1'b1;
        if (is_pass) push_pass(sel, ap);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int base;
        int k;
        base = done_cnt;
        k    = 0;
        while (done_cnt == base && k < 30000) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_done_seen"}, 32'(done_cnt != base), 32'd1);
        chk({name, "_sb_drained"}, 32'(sbq.size()), 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_busy_cleared"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rd0"}, 32'(ant0_rd), 0);
        chk({tag, "_rd1"}, 32'(ant1_rd), 0);
        chk({tag, "_raddr0"}, 32'(ant0_raddr), 0);
        chk({tag, "_raddr1"}, 32'(ant1_raddr), 0);
        chk({tag, "_valid"}, 32'(dout_valid), 0);
        chk({tag, "_data"}, 32'(dout_data), 0);
        chk({tag, "_ant"}, 32'(dout_ant), 0);
        chk({tag, "_sop"}, 32'(dout_sop), 0);
        chk({tag, "_eop"}, 32'(dout_eop), 0);
    endtask

    initial begin
        int k;
        int x0;

        // Reset state, N=512, ap_num=00
        #3;
        chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pass 1: ant0 only, N=512, check start-to-first-valid latency
        do_start(2'b11, 2'b00, 1);
        @(negedge clk);
        k = 1;
        chk("busy_after_start", 32'(busy), 32'd1);
        while (!dout_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("first_valid_latency", 32'(k), 32'(RAM_LAT + 2));
        wait_done("p1");

        // Pass 2: both antennas, N=1024
        do_start(2'b10, 2'b01, 1);
        wait_done("p2");

        // Pass 3: both antennas, N=512, random ready, with a start while busy
        rnd_mode = 1;
        do_start(2'b11, 2'b01, 1);
        repeat (100) @(posedge clk);
        #1;
        ifft_size_sel = 2'b00;
        ap_num        = 2'b10;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_midpass_start", 32'(busy), 32'd1);
        wait_done("p3");
        rnd_mode = 0;

        // Idle start with ap_num=10: done next cycle, no busy, no transfers
        x0 = xfer;
        @(posedge clk);
        #1;
        ap_num = 2'b10;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        nopass_exp = 1;
        @(negedge clk);
        chk("nopass_done", 32'(done), 32'd1);
        chk("nopass_busy", 32'(busy), 32'd0);
        @(posedge clk);
        nopass_exp = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("nopass_xfers", 32'(xfer - x0), 32'd0);

        // Pass 4: N=4096, reset asserted at sample 300
        do_start(2'b00, 2'b00, 1);
        k = 0;
        while (xfer < 300 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("reach_sample_300", 32'(xfer >= 300), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        sbq.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pass 5: clean pass from addr 0 after the reset
        do_start(2'b11, 2'b00, 1);
        wait_done("p5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
